irq_sched: RTL and testbench
============================

Name: irq_sched

Overview:
Interrupt scheduler for the 5-stage pipeline CPU. It synchronises and edge-detects the raw interrupt request lines and keeps per-source pending and in-service state. It applies the global enable, the per-source mask and the priority rule, then issues a single take request with a vector address. The interrupt/flush controller uses that request to force the PC and flush IF/ID/EX; `eret` retiring in WB closes the in-service level.

Parameters:
- NSRC, 3, number of interrupt sources; index NSRC-1 is the highest priority.
- SYNC_STAGES, 2, synchroniser flops per source (minimum 2).
- VEC_BASE, 32'h0000_0100, vector address of source 0.
- VEC_STRIDE, 32'h0000_0040, address spacing between source vectors.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- in_RST_n, input, 1, asynchronous active-low reset.
- en, input, 1, pipeline advance enable; low = pipeline stalled.
- irq_in, input, NSRC, raw asynchronous request lines; a rising edge means a request.
- ie, input, 1, global interrupt enable (CP0 status).
- inm, input, NSRC, per-source mask; 1 = masked.
- take_ack, input, 1, one-cycle pulse: the pipeline has flushed and redirected to take_vec.
- eret, input, 1, one-cycle pulse: eret retiring in WB.
- take_req, output, 1, request to flush and force the PC.
- take_vec, output, 32, vector address; stable while take_req is high.
- take_id, output, 2, index of the requested source.
- pending, output, NSRC, pending requests.
- in_service, output, NSRC, nested in-service bits (drives the status LEDs).

Behaviour:
- Reset:
  - All outputs are 0, including take_vec.
  - Synchroniser and previous-value flops reset to 0, so a line held high through reset yields exactly one edge after release.
  - The FSM resets to IDLE.
- Edge capture:
  - Each source passes through SYNC_STAGES flops, then rise = sync & ~prev.
  - rise sets pending[i]. Capture is independent of en, ie, inm and the FSM state.
  - A rise on an already-pending source is dropped (no counting).
  - Latency: an irq_in edge sampled at cycle 0 makes pending visible at cycle SYNC_STAGES+1.
- Eligibility:
  - elig[i] = pending[i] & ~inm[i] & ie & (i > highest set in_service index); with in_service all 0, every pending unmasked source qualifies.
  - sel = highest-index eligible source.
- FSM IDLE:
  - If any elig and en: latch sel into take_id, take_vec = VEC_BASE + sel*VEC_STRIDE (32-bit wrap), go to REQ. take_req rises the next cycle.
- FSM REQ:
  - take_req = 1. take_id and take_vec are frozen; a higher-priority arrival does not retarget an outstanding request.
  - take_ack & en: clear pending[take_id], set in_service[take_id], take_req = 0, go to IDLE.
  - take_ack with en = 0 is ignored and the request holds.
  - Changes to ie or inm during REQ do not withdraw the request.
- eret:
  - Clears the highest set in_service bit.
  - eret with in_service all 0 is a no-op.
  - eret and take_ack in the same cycle: clear the highest bit first, then set the new bit (the new bit may be the same index).
- Nesting:
  - Depth is at most NSRC; only strictly higher priority preempts.
  - A source that is in service can become pending again; it is re-taken after its eret.
- Reset mid-operation: asynchronous clear of everything, including an outstanding take_req.
- take_req, take_vec and take_id are registered outputs with no combinational path from inputs.

Optional Feature:
- Macro: IRQ_CNT_EN.
- Defined:
  - Adds output irq_cnt [NSRC*16-1:0], one 16-bit counter per source.
  - A counter increments on each accepted take (take_ack & en in REQ) for that source and saturates at 16'hFFFF.
  - Counters reset to 0 on in_RST_n.
- Not defined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package irq_pkg:
  - FSM state encoding (IDLE, REQ).
  - Localparams for the id width (clog2 of NSRC) and counter width 16.
  - Default VEC_BASE and VEC_STRIDE values.
- Sub-module irq_sync_edge: one instance per source; SYNC_STAGES synchroniser plus rise detector with the same asynchronous active-low reset.
- Priority select, FSM and in-service stack stay in irq_sched.

Test Plan:
- Basic take:
  - Stimulus: ie=1, inm=0, pulse irq_in[0] high.
  - Response: pending=3'b001 after 3 cycles; take_req=1 with take_vec=32'h100, take_id=0; on take_ack, in_service=3'b001 and pending=0.
- Priority and masking:
  - Stimulus: rise irq_in[2:1] in the same cycle with inm=3'b100.
  - Response: take_id=1, take_vec=32'h140; after inm=0 and the first ack, source 2 (32'h180) is taken, nesting gives in_service=3'b110, and one eret leaves 3'b010.
- No lower-priority preemption:
  - Stimulus: in_service=3'b100, then rise irq_in[0].
  - Response: pending=3'b001 and take_req stays 0 until eret; then take_vec=32'h100.
- Stall:
  - Stimulus: hold en=0 while in REQ and pulse take_ack.
  - Response: take_req stays 1 and in_service is unchanged; with en=1 the ack is accepted.
- Simultaneous eret and ack:
  - Stimulus: in_service=3'b010 with a pending request for source 2 in REQ; eret and take_ack in the same cycle.
  - Response: in_service=3'b100.
- Reset mid-request:
  - Stimulus: drive in_RST_n low while take_req=1.
  - Response: all outputs are 0 immediately. With IRQ_CNT_EN defined, irq_cnt is 0; and 65536 takes of source 0 leave irq_cnt[15:0]=16'hFFFF.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt scheduler.
//   ST_IDLE/ST_REQ  : take-request FSM states
//   ID_W, CNT_W     : source index width and take-counter width
//   VEC_*_DEF       : default vector base and stride
//   vec_addr()      : vector address of a source (32-bit wrap)
package irq_pkg;

   localparam int unsigned NSRC_DEF = 3;
   localparam int unsigned ID_W     = $clog2(NSRC_DEF);
   localparam int unsigned CNT_W    = 16;

   localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
   localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0040;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_t;

   function automatic logic [31:0] vec_addr(input logic [31:0]     base,
                                            input logic [31:0]     stride,
                                            input logic [ID_W-1:0] id);
      return base + stride * 32'(id);
   endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Synchroniser plus rising-edge detector for one raw interrupt line.
//   clk, rst_n : clock, asynchronous active-low reset
//   irq        : raw asynchronous request line
//   rise_c     : one-cycle pulse (combinational from flops) on a synchronised 0->1
module irq_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic irq,
   output logic rise_c
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Reset to 0 so a line held high through reset gives exactly one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_sched.sv
// Interrupt scheduler: edge capture, pending/in-service tracking, priority
// select and a single registered take request with vector address.
// Optional feature macro: IRQ_CNT_EN adds per-source saturating take counters.
//   clk, in_RST_n  : clock, asynchronous active-low reset
//   en             : pipeline advance enable
//   irq_in         : raw request lines (rising edge = request)
//   ie, inm        : global enable, per-source mask (1 = masked)
//   take_ack, eret : take accepted by pipeline / eret retiring in WB
//   take_req/vec/id: registered take request, vector and source index
//   pending        : pending requests
//   in_service     : nested in-service bits
//   irq_cnt        : (IRQ_CNT_EN) 16-bit accepted-take count per source
module irq_sched
   import irq_pkg::*;
#(
   parameter int unsigned NSRC        = NSRC_DEF,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [31:0] VEC_BASE    = VEC_BASE_DEF,
   parameter logic [31:0] VEC_STRIDE  = VEC_STRIDE_DEF
) (
   input  logic              clk,
   input  logic              in_RST_n,
   input  logic              en,
   input  logic [NSRC-1:0]   irq_in,
   input  logic              ie,
   input  logic [NSRC-1:0]   inm,
   input  logic              take_ack,
   input  logic              eret,
   output logic              take_req,
   output logic [31:0]       take_vec,
   output logic [ID_W-1:0]   take_id,
   output logic [NSRC-1:0]   pending,
   output logic [NSRC-1:0]   in_service
`ifdef IRQ_CNT_EN
   ,
   output logic [NSRC*CNT_W-1:0] irq_cnt
`endif
);

   state_t            state_q;
   state_t            state_d;
   logic [NSRC-1:0]   rise_c;
   logic [NSRC-1:0]   elig_c;
   logic              any_elig_c;
   logic [ID_W-1:0]   sel_c;
   logic              accept_c;
   logic [NSRC-1:0]   id_oh_c;
   logic              take_req_d;
   logic [31:0]       take_vec_d;
   logic [ID_W-1:0]   take_id_d;
   logic [NSRC-1:0]   pending_d;
   logic [NSRC-1:0]   in_service_d;

   // Per-source synchroniser and edge detector.
   for (genvar g = 0; g < int'(NSRC); g++) begin : g_sync
      irq_sync_edge #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
         .clk    (clk),
         .rst_n  (in_RST_n),
         .irq    (irq_in[g]),
         .rise_c (rise_c[g])
      );
   end

   // Eligibility: only sources strictly above the highest in-service level.
   always_comb begin : p_elig
      logic seen;
      seen   = 1'b0;
      elig_c = '0;
      for (int i = int'(NSRC) - 1; i >= 0; i--) begin
         seen      = seen | in_service[i];
         elig_c[i] = pending[i] & ~inm[i] & ie & ~seen;
      end
   end

   // Highest-index eligible source wins.
   always_comb begin
      sel_c = '0;
      for (int i = 0; i < int'(NSRC); i++) begin
         if (elig_c[i]) sel_c = ID_W'(i);
      end
   end

   assign any_elig_c = |elig_c;

   // FSM state register.
   always_ff @(posedge clk or negedge in_RST_n) begin
      if (!in_RST_n) state_q <= ST_IDLE;
      else           state_q <= state_d;
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (any_elig_c && en) state_d = ST_REQ;
         ST_REQ:  if (take_ack && en)   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: request fields are latched on entry to REQ and frozen there.
   always_comb begin
      take_req_d = take_req;
      take_vec_d = take_vec;
      take_id_d  = take_id;
      accept_c   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (any_elig_c && en) begin
               take_req_d = 1'b1;
               take_id_d  = sel_c;
               take_vec_d = vec_addr(VEC_BASE, VEC_STRIDE, sel_c);
            end
         end
         ST_REQ: begin
            if (take_ack && en) begin
               take_req_d = 1'b0;
               accept_c   = 1'b1;
            end
         end
         default: take_req_d = 1'b0;
      endcase
   end

   // Pending capture and in-service stack; eret pops before an accept pushes.
   always_comb begin : p_stack
      logic done;
      done         = 1'b0;
      id_oh_c      = NSRC'(1'b1) << take_id;
      pending_d    = pending | rise_c;
      in_service_d = in_service;
      if (eret) begin
         for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (!done && in_service[i]) begin
               in_service_d[i] = 1'b0;
               done            = 1'b1;
            end
         end
      end
      if (accept_c) begin
         pending_d    = pending_d & ~id_oh_c;
         in_service_d = in_service_d | id_oh_c;
      end
   end

   always_ff @(posedge clk or negedge in_RST_n) begin
      if (!in_RST_n) begin
         take_req   <= 1'b0;
         take_vec   <= '0;
         take_id    <= '0;
         pending    <= '0;
         in_service <= '0;
      end else begin
         take_req   <= take_req_d;
         take_vec   <= take_vec_d;
         take_id    <= take_id_d;
         pending    <= pending_d;
         in_service <= in_service_d;
      end
   end

`ifdef IRQ_CNT_EN
   logic [CNT_W-1:0] cnt_q [NSRC];

   // Saturating count of accepted takes per source.
   always_ff @(posedge clk or negedge in_RST_n) begin
      if (!in_RST_n) begin
         for (int i = 0; i < int'(NSRC); i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < int'(NSRC); i++) begin
            if (accept_c && (take_id == ID_W'(i)) && (cnt_q[i] != {CNT_W{1'b1}}))
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
         end
      end
   end

   for (genvar g = 0; g < int'(NSRC); g++) begin : g_cnt
      assign irq_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
   end
`endif

endmodule

// File: tb/tb_irq_sched.sv
// Self-checking bench for irq_sched: directed scenarios plus random traffic,
// all compared cycle by cycle against a behavioural scheduler model.
module tb_irq_sched;

   localparam int NSRC = 3;
   localparam int SYNC = 2;
   localparam logic [31:0] VB = 32'h0000_0100;
   localparam logic [31:0] VS = 32'h0000_0040;

   logic        clk = 1'b0;
   logic        in_RST_n;
   logic        en;
   logic [2:0]  irq_in;
   logic        ie;
   logic [2:0]  inm;
   logic        take_ack;
   logic        eret;
   logic        take_req;
   logic [31:0] take_vec;
   logic [1:0]  take_id;
   logic [2:0]  pending;
   logic [2:0]  in_service;
`ifdef IRQ_CNT_EN
   logic [47:0] irq_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // Model state
   bit [2:0]  m_pend;
   bit [2:0]  m_isv;
   bit        m_req;
   int        m_id;
   bit [31:0] m_vec;
   bit [2:0]  hist[$];
   int        m_cnt[NSRC];

   always #5 clk = ~clk;

   irq_sched dut (
      .clk        (clk),
      .in_RST_n   (in_RST_n),
      .en         (en),
      .irq_in     (irq_in),
      .ie         (ie),
      .inm        (inm),
      .take_ack   (take_ack),
      .eret       (eret),
      .take_req   (take_req),
      .take_vec   (take_vec),
      .take_id    (take_id),
      .pending    (pending),
      .in_service (in_service)
`ifdef IRQ_CNT_EN
      ,
      .irq_cnt    (irq_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int top_index(input bit [2:0] v);
      int r = -1;
      for (int i = 0; i < NSRC; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i <= SYNC; i++) hist.push_back(3'b000);
      m_pend = '0;
      m_isv  = '0;
      m_req  = 1'b0;
      m_id   = 0;
      m_vec  = '0;
      for (int i = 0; i < NSRC; i++) m_cnt[i] = 0;
   endtask

   // Advance the model across the coming rising edge using the driven inputs.
   task automatic model_step();
      bit [2:0] rise;
      bit [2:0] np;
      bit       acc;
      int       hi;
      int       sel;
      hist.push_back(irq_in);
      if (hist.size() > SYNC + 2) void'(hist.pop_front());
      // A request is seen SYNC edges after it was sampled high following a low.
      rise = hist[1] & ~hist[0];
      hi   = top_index(m_isv);
      acc  = 1'b0;
      if (m_req) begin
         if (take_ack && en) begin
            acc   = 1'b1;
            m_req = 1'b0;
         end
      end else if (en && ie) begin
         sel = -1;
         for (int i = 0; i < NSRC; i++)
            if (m_pend[i] && !inm[i] && i > hi) sel = i;
         if (sel >= 0) begin
            m_req = 1'b1;
            m_id  = sel;
            m_vec = VB + VS * 32'(sel);
         end
      end
      np = m_pend;
      for (int i = 0; i < NSRC; i++) if (rise[i] && !m_pend[i]) np[i] = 1'b1;
      if (eret && hi >= 0) m_isv[hi] = 1'b0;
      if (acc) begin
         np[m_id]    = 1'b0;
         m_isv[m_id] = 1'b1;
         if (m_cnt[m_id] < 65535) m_cnt[m_id]++;
      end
      m_pend = np;
   endtask

   task automatic check_outputs();
      chk("take_req", 32'(take_req), 32'(m_req));
      chk("pending", 32'(pending), 32'(m_pend));
      chk("in_service", 32'(in_service), 32'(m_isv));
      if (m_req) begin
         chk("take_id", 32'(take_id), 32'(m_id));
         chk("take_vec", take_vec, m_vec);
      end
`ifdef IRQ_CNT_EN
      for (int i = 0; i < NSRC; i++)
         chk("irq_cnt", 32'(irq_cnt[i*16 +: 16]), 32'(m_cnt[i]));
`endif
   endtask

   // One clock: apply pulses, predict, then compare at the falling edge.
   task automatic tick(input bit ack, input bit er);
      take_ack = ack;
      eret     = er;
      model_step();
      @(negedge clk);
      take_ack = 1'b0;
      eret     = 1'b0;
      check_outputs();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_req"}, 32'(take_req), 32'd0);
      chk({tag, "_vec"}, take_vec, 32'd0);
      chk({tag, "_id"}, 32'(take_id), 32'd0);
      chk({tag, "_pend"}, 32'(pending), 32'd0);
      chk({tag, "_isv"}, 32'(in_service), 32'd0);
`ifdef IRQ_CNT_EN
      chk({tag, "_cnt"}, 32'(irq_cnt[31:0]) | 32'(irq_cnt[47:32]), 32'd0);
`endif
   endtask

   // Asynchronous reset pulse between two falling edges.
   task automatic do_reset();
      #1 in_RST_n = 1'b0;
      #1 check_zero("rst_mid");
      model_reset();
      #1 in_RST_n = 1'b1;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!m_req && n < 20) begin
         tick(1'b0, 1'b0);
         n++;
      end
      chk("wait_req", 32'(take_req), 32'd1);
   endtask

   initial begin
      in_RST_n = 1'b0;
      en = 1'b1; ie = 1'b1; inm = '0; irq_in = '0; take_ack = 1'b0; eret = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_zero("reset");
      in_RST_n = 1'b1;

      // Basic take of source 0
      irq_in = 3'b001; tick(0, 0);
      irq_in = 3'b000; tick(0, 0); tick(0, 0);
      chk("basic_pend", 32'(pending), 32'h1);
      wait_req();
      chk("basic_vec", take_vec, 32'h100);
      chk("basic_id", 32'(take_id), 32'd0);
      tick(1, 0);
      chk("basic_isv", 32'(in_service), 32'h1);
      chk("basic_pclr", 32'(pending), 32'h0);
      tick(0, 1);

      // Priority with source 2 masked, then nesting
      inm = 3'b100;
      irq_in = 3'b110; tick(0, 0);
      irq_in = 3'b000;
      wait_req();
      chk("prio_id", 32'(take_id), 32'd1);
      chk("prio_vec", take_vec, 32'h140);
      inm = 3'b000;
      tick(1, 0);
      wait_req();
      chk("nest_vec", take_vec, 32'h180);
      tick(1, 0);
      chk("nest_isv", 32'(in_service), 32'h6);
      tick(0, 1);
      chk("nest_eret", 32'(in_service), 32'h2);

      // eret and take_ack together
      irq_in = 3'b100; tick(0, 0);
      irq_in = 3'b000;
      wait_req();
      tick(1, 1);
      chk("eret_ack_isv", 32'(in_service), 32'h4);

      // Lower priority must not preempt
      irq_in = 3'b001; tick(0, 0);
      irq_in = 3'b000;
      repeat (6) tick(0, 0);
      chk("nopre_req", 32'(take_req), 32'd0);
      chk("nopre_pend", 32'(pending), 32'h1);
      tick(0, 1);
      wait_req();
      chk("nopre_vec", take_vec, 32'h100);
      tick(1, 0);
      tick(0, 1);

      // Ack ignored while stalled
      irq_in = 3'b010; tick(0, 0);
      irq_in = 3'b000;
      wait_req();
      en = 1'b0;
      tick(1, 0);
      chk("stall_req", 32'(take_req), 32'd1);
      chk("stall_isv", 32'(in_service), 32'h0);
      en = 1'b1;
      tick(1, 0);
      chk("stall_acc", 32'(in_service), 32'h2);
      tick(0, 1);

      // Reset while a request is outstanding
      irq_in = 3'b001; tick(0, 0);
      irq_in = 3'b000;
      wait_req();
      do_reset();
      tick(0, 0);

      // Random traffic
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(5) == 0) irq_in = irq_in ^ (3'b001 << $urandom_range(2));
         ie = ($urandom_range(15) != 0);
         if ($urandom_range(19) == 0) inm = 3'($urandom);
         en = ($urandom_range(4) != 0);
         if (c % 700 == 699) do_reset();
         tick(bit'(m_req && ($urandom_range(2) == 0)), bit'($urandom_range(9) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
